// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle for lsu_mem_ctrl: request/response channel from the datapath plus
// the word-organised data memory port.
interface lsu_mem_ctrl_if #(parameter int XLEN = 32);
   // Request handshake: a request transfers on a rising edge where req_valid && req_ready.
   // The requester holds all req_* fields stable while req_valid is high and not yet accepted.
   // rsp_valid is a single-cycle pulse with no back-pressure; rsp_rdata/rsp_err belong to it.
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_we;
   logic [XLEN-1:0] mem_rdata;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit driving a word memory with 1-cycle read latency; sub-word
// stores use read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module lsu_mem_ctrl #(
   parameter int MEM_AW = 8,
   parameter int XLEN   = 32
) (
   input  logic           CLK,
   input  logic           RST,
   lsu_mem_ctrl_if.master bus,
   output logic [2:0]     dbg_state
);
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_t;

   localparam logic [XLEN-1:0] BYTE_MASK = {{(XLEN-8){1'b0}}, 8'hFF};
   localparam logic [XLEN-1:0] HALF_MASK = {{(XLEN-16){1'b0}}, 16'hFFFF};

   state_t            state, state_nxt;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [MEM_AW+1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   rdata_q;
   logic              err_q;

   logic              unsupported, misalign, req_err;
   logic [MEM_AW+1:0] req_ea;
   logic [4:0]        shamt;
   logic [XLEN-1:0]   shifted, load_val, lane_mask, lane_data, merged;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr[XLEN-1:MEM_AW+2];

   // Request decode: error classification and the effective (possibly realigned) address.
   always_comb begin
      if (bus.req_we)
         unsupported = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
      else
         unsupported = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
      misalign = 1'b0;
      req_ea   = bus.req_addr[MEM_AW+1:0];
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
      if (bus.req_funct3[1:0] == 2'b01)
         req_ea[0] = 1'b0;
      else if (bus.req_funct3[1:0] == 2'b10)
         req_ea[1:0] = 2'b00;
`endif
      req_err = unsupported || misalign;
   end

   // Lane extraction and merge work on the read word shifted by the byte offset.
   always_comb begin
      shamt   = {addr_q[1:0], 3'b000};
      shifted = bus.mem_rdata >> shamt;
      case (f3_q)
         3'b000:  load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b100:  load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_val = bus.mem_rdata;
      endcase
      lane_mask = ((f3_q[1:0] == 2'b00) ? BYTE_MASK : HALF_MASK) << shamt;
      lane_data = (wdata_q & ((f3_q[1:0] == 2'b00) ? BYTE_MASK : HALF_MASK)) << shamt;
      merged    = (bus.mem_rdata & ~lane_mask) | lane_data;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (req_err)
                  state_nxt = RESP;
               else if (bus.req_we && (bus.req_funct3[1:0] == 2'b10))
                  state_nxt = WR;
               else
                  state_nxt = RD;
            end
         end
         RD:      state_nxt = CAP;
         CAP:     state_nxt = we_q ? WR : RESP;
         WR:      state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q   <= bus.req_we;
                  f3_q   <= bus.req_funct3;
                  addr_q <= req_ea;
                  if (bus.req_we)
                     wdata_q <= bus.req_wdata;
                  if (req_err) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            CAP: begin
               if (we_q) begin
                  wdata_q <= merged;
               end else begin
                  rdata_q <= load_val;
                  err_q   <= 1'b0;
               end
            end
            WR: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // mem_we is gated by RST so a reset landing in WR never commits the write.
   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.mem_addr  = {{(XLEN-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_we    = (state == WR) && !RST;
   assign dbg_state     = state;
endmodule
